// File: rtl/axi_extract_tlast_fifo_if.sv
// Stream bundle for axi_extract_tlast_fifo: untagged input side plus tlast-restored output side.
// The design drives through the slave modport; the upstream/downstream pair uses master.
interface axi_extract_tlast_fifo_if #(
    parameter int WIDTH = 64
);
    logic [WIDTH-1:0] i_tdata;
    logic             i_tvalid;
    logic             i_tready;
    logic [WIDTH-1:0] o_tdata;
    logic             o_tlast;
    logic             o_tvalid;
    logic             o_tready;

    modport master (
        output i_tdata, i_tvalid, o_tready,
        input  i_tready, o_tdata, o_tlast, o_tvalid
    );

    modport slave (
        input  i_tdata, i_tvalid, o_tready,
        output i_tready, o_tdata, o_tlast, o_tvalid
    );
endinterface

// File: rtl/axi_extract_tlast_fifo.sv
// Removes in-band tlast escape sequences and restores o_tlast behind a 2**SIZE-entry FIFO.
// Define AXI_EXTRACT_TLAST_STATS_EN to add the pkt_count/esc_count statistics outputs.
module axi_extract_tlast_fifo #(
    parameter int               WIDTH  = 64,
    parameter logic [WIDTH-1:0] ESCAPE = 64'hDEADBEEFFEEDCAFE,
    parameter int               SIZE   = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clear,
    axi_extract_tlast_fifo_if.slave bus,
    output logic [SIZE:0]         occupied,
    output logic                  ctrl_err
`ifdef AXI_EXTRACT_TLAST_STATS_EN
    ,
    output logic [31:0]           pkt_count,
    output logic [31:0]           esc_count
`endif
);
    localparam int              DEPTH    = 2 ** SIZE;
    localparam logic [SIZE:0]   FULL_CNT = (SIZE + 1)'(DEPTH);
    localparam logic [SIZE:0]   CNT_ONE  = (SIZE + 1)'(1);
    localparam logic [SIZE-1:0] PTR_ONE  = SIZE'(1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ESC   = 2'd1,
        ST_TLAST = 2'd2,
        ST_LIT   = 2'd3
    } state_t;

    state_t           state_r;
    state_t           state_next_s;
    logic [WIDTH:0]   mem_r [DEPTH];
    logic [SIZE-1:0]  wr_ptr_r;
    logic [SIZE-1:0]  rd_ptr_r;
    logic [SIZE:0]    occupied_r;
    logic [SIZE:0]    occ_next_s;
    logic             i_tready_r;
    logic             o_tvalid_r;
    logic             ctrl_err_r;
    logic             flush_s;
    logic             accept_s;
    logic             emit_s;
    logic             is_escape_s;
    logic             wr_en_s;
    logic             wr_last_s;
    logic             ctrl_bad_s;

    assign flush_s     = reset | clear;
    assign accept_s    = bus.i_tvalid & i_tready_r;
    assign emit_s      = o_tvalid_r & bus.o_tready;
    assign is_escape_s = (bus.i_tdata == ESCAPE);

    // Parser state register; only an accepted word moves the parser.
    always_ff @(posedge clk) begin
        if (flush_s) begin
            state_r <= ST_IDLE;
        end else if (accept_s) begin
            state_r <= state_next_s;
        end
    end

    // Parser next-state decode.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (is_escape_s) begin
                    state_next_s = ST_ESC;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_ESC: begin
                if (bus.i_tdata[31:0] == 32'd1) begin
                    state_next_s = ST_TLAST;
                end else begin
                    state_next_s = ST_LIT;
                end
            end
            ST_TLAST: state_next_s = ST_IDLE;
            ST_LIT:   state_next_s = ST_IDLE;
            default:  state_next_s = ST_IDLE;
        endcase
    end

    // Parser output decode: which accepted words reach the FIFO and with what tlast.
    always_comb begin
        wr_en_s    = 1'b0;
        wr_last_s  = 1'b0;
        ctrl_bad_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                wr_en_s = accept_s & ~is_escape_s;
            end
            ST_ESC: begin
                // Control words are consumed; anything above 1 is flagged and treated as literal.
                ctrl_bad_s = accept_s & (bus.i_tdata[31:1] != 31'd0);
            end
            ST_TLAST: begin
                wr_en_s   = accept_s;
                wr_last_s = 1'b1;
            end
            ST_LIT: begin
                wr_en_s = accept_s;
            end
            default: begin
                wr_en_s    = 1'b0;
                wr_last_s  = 1'b0;
                ctrl_bad_s = 1'b0;
            end
        endcase
    end

    // Next occupancy; simultaneous write and emit leave it unchanged.
    always_comb begin
        occ_next_s = occupied_r;
        case ({wr_en_s, emit_s})
            2'b10:   occ_next_s = occupied_r + CNT_ONE;
            2'b01:   occ_next_s = occupied_r - CNT_ONE;
            default: occ_next_s = occupied_r;
        endcase
    end

    // FIFO pointers, occupancy and registered handshake flags.
    always_ff @(posedge clk) begin
        if (flush_s) begin
            wr_ptr_r   <= {SIZE{1'b0}};
            rd_ptr_r   <= {SIZE{1'b0}};
            occupied_r <= {(SIZE + 1){1'b0}};
            i_tready_r <= 1'b1;
            o_tvalid_r <= 1'b0;
            ctrl_err_r <= 1'b0;
        end else begin
            if (wr_en_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (emit_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            occupied_r <= occ_next_s;
            // Ready derives from next occupancy so no path exists from o_tready to i_tready.
            i_tready_r <= (occ_next_s != FULL_CNT);
            o_tvalid_r <= (occ_next_s != {(SIZE + 1){1'b0}});
            ctrl_err_r <= ctrl_bad_s;
        end
    end

    // FIFO storage: {tlast, data} per entry.
    always_ff @(posedge clk) begin
        if (wr_en_s && !flush_s) begin
            mem_r[wr_ptr_r] <= {wr_last_s, bus.i_tdata};
        end
    end

    assign bus.i_tready = i_tready_r;
    assign bus.o_tvalid = o_tvalid_r;
    assign bus.o_tdata  = mem_r[rd_ptr_r][WIDTH-1:0];
    assign bus.o_tlast  = mem_r[rd_ptr_r][WIDTH];
    assign occupied     = occupied_r;
    assign ctrl_err     = ctrl_err_r;

`ifdef AXI_EXTRACT_TLAST_STATS_EN
    logic [31:0] pkt_count_r;
    logic [31:0] esc_count_r;

    // Packet and escape statistics, wrapping naturally at 2**32.
    always_ff @(posedge clk) begin
        if (flush_s) begin
            pkt_count_r <= 32'd0;
            esc_count_r <= 32'd0;
        end else begin
            if (emit_s && bus.o_tlast) begin
                pkt_count_r <= pkt_count_r + 32'd1;
            end
            if (accept_s && (state_r == ST_ESC)) begin
                esc_count_r <= esc_count_r + 32'd1;
            end
        end
    end

    assign pkt_count = pkt_count_r;
    assign esc_count = esc_count_r;
`endif
endmodule

// File: tb/tb_axi_extract_tlast_fifo.sv
// Scoreboard bench for axi_extract_tlast_fifo (SIZE=2): directed escape cases plus random traffic.
module tb_axi_extract_tlast_fifo;
    localparam int          WIDTH = 64;
    localparam int          SIZE  = 2;
    localparam logic [63:0] ESC   = 64'hDEADBEEFFEEDCAFE;

    logic            clk = 1'b0;
    logic            reset;
    logic            clear;
    logic [SIZE:0]   occupied;
    logic            ctrl_err;
`ifdef AXI_EXTRACT_TLAST_STATS_EN
    logic [31:0]     pkt_count;
    logic [31:0]     esc_count;
`endif

    axi_extract_tlast_fifo_if #(.WIDTH(WIDTH)) bus ();

    axi_extract_tlast_fifo #(.WIDTH(WIDTH), .ESCAPE(ESC), .SIZE(SIZE)) dut (
        .clk      (clk),
        .reset    (reset),
        .clear    (clear),
        .bus      (bus),
        .occupied (occupied),
        .ctrl_err (ctrl_err)
`ifdef AXI_EXTRACT_TLAST_STATS_EN
        ,
        .pkt_count(pkt_count),
        .esc_count(esc_count)
`endif
    );

    always #5 clk = ~clk;

    int           checks = 0;
    int           errors = 0;
    int           cyc = 0;
    int           rdy_mode = 0;
    int           mstate = 0;   // 0 normal, 1 after escape, 2 next word ends packet, 3 next word literal
    int           pkt_model = 0;
    int           esc_model = 0;
    int           last_acc = 0;
    bit           monitor_en = 1'b0;
    logic [64:0]  exp_q[$];
    logic [64:0]  mon_exp;
    bit           err_at[int];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [64:0] act, input logic [64:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: applies the escape rules to each word the DUT accepts.
    task automatic model_accept(input logic [63:0] w);
        if (mstate == 0) begin
            if (w == ESC) mstate = 1;
            else exp_q.push_back({1'b0, w});
        end else if (mstate == 1) begin
            esc_model++;
            if (w[31:0] == 32'd1) begin
                mstate = 2;
            end else begin
                if (w[31:0] != 32'd0) err_at[cyc + 1] = 1'b1;
                mstate = 3;
            end
        end else begin
            exp_q.push_back({(mstate == 2), w});
            mstate = 0;
        end
    endtask

    task automatic send(input logic [63:0] w);
        int t = 0;
        bit done = 1'b0;
        bus.i_tdata  = w;
        bus.i_tvalid = 1'b1;
        while (!done) begin
            @(negedge clk);
            if (bus.i_tready) begin
                model_accept(w);
                last_acc = cyc + 1;
                done = 1'b1;
            end else begin
                t++;
                if (t > 200) begin
                    checks++;
                    errors++;
                    $display("FAIL send_timeout: got i_tready=0 expected 1 within 200 cycles");
                    done = 1'b1;
                end
            end
            @(posedge clk);
            #1;
        end
        bus.i_tvalid = 1'b0;
    endtask

    task automatic drain();
        int t = 0;
        rdy_mode = 1;
        bus.o_tready = 1'b1;
        while (exp_q.size() != 0 && t < 400) begin
            @(negedge clk);
            t++;
        end
        check("drain_queue_empty", 65'(exp_q.size()), 65'd0);
        @(posedge clk);
        #1;
        check("drain_occupied", 65'(occupied), 65'd0);
        check("drain_o_tvalid", 65'(bus.o_tvalid), 65'd0);
    endtask

    task automatic do_clear();
        clear = 1'b1;
        @(posedge clk);
        #1;
        clear = 1'b0;
        exp_q.delete();
        err_at.delete();
        mstate = 0;
        pkt_model = 0;
        esc_model = 0;
    endtask

    // Downstream ready generator.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rdy_mode == 0) bus.o_tready = 1'b0;
            else if (rdy_mode == 1) bus.o_tready = 1'b1;
            else bus.o_tready = ($urandom_range(0, 1) == 1);
        end
    end

    // Monitor: compares every emitted word and the ctrl_err pulse each cycle.
    initial begin
        forever begin
            @(negedge clk);
            if (monitor_en && !reset && !clear) begin
                check("ctrl_err", 65'(ctrl_err), 65'(err_at.exists(cyc)));
                if (bus.o_tvalid && bus.o_tready) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_output: got %0h expected no output", bus.o_tdata);
                    end else begin
                        mon_exp = exp_q.pop_front();
                        check("o_tdata", 65'(bus.o_tdata), 65'(mon_exp[63:0]));
                        check("o_tlast", 65'(bus.o_tlast), 65'(mon_exp[64]));
                        if (mon_exp[64]) pkt_model++;
                    end
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int idx;
        int first_acc;
        logic [63:0] w;
        logic [63:0] prev;
        reset = 1'b1;
        clear = 1'b0;
        bus.i_tvalid = 1'b0;
        bus.i_tdata = 64'd0;
        bus.o_tready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("reset_occupied", 65'(occupied), 65'd0);
        check("reset_o_tvalid", 65'(bus.o_tvalid), 65'd0);
        check("reset_i_tready", 65'(bus.i_tready), 65'd1);
        check("reset_ctrl_err", 65'(ctrl_err), 65'd0);
        monitor_en = 1'b1;
        @(posedge clk);
        #1;

        // 1,2,ESC,1,3 -> 1,2,3 with tlast on 3; one-cycle latency on the first word.
        rdy_mode = 1;
        bus.o_tready = 1'b1;
        send(64'd1);
        check("latency_o_tvalid", 65'(bus.o_tvalid), 65'd1);
        check("latency_o_tdata", 65'(bus.o_tdata), 65'd1);
        send(64'd2); send(ESC); send(64'd1); send(64'd3);
        drain();

        // Literal escape, then bad control word.
        send(ESC); send(64'd0); send(ESC); send(64'd5);
        drain();
        send(ESC); send(64'd7); send(64'd9);
        drain();

        // Fill with downstream stalled: four stored, ready drops.
        rdy_mode = 0;
        bus.o_tready = 1'b0;
        idx = 0;
        bus.i_tvalid = 1'b1;
        bus.i_tdata = 64'd100;
        repeat (8) begin
            @(negedge clk);
            if (bus.i_tready) begin
                model_accept(bus.i_tdata);
                idx++;
            end
            @(posedge clk);
            #1;
            bus.i_tdata = 64'(100 + idx);
        end
        bus.i_tvalid = 1'b0;
        check("full_accepted", 65'(idx), 65'd4);
        check("full_occupied", 65'(occupied), 65'd4);
        check("full_i_tready", 65'(bus.i_tready), 65'd0);
        rdy_mode = 1;
        bus.o_tready = 1'b1;
        while (idx < 6) begin
            send(64'(100 + idx));
            idx++;
        end
        drain();

        // Throughput from a full FIFO with both sides always ready.
        rdy_mode = 0;
        bus.o_tready = 1'b0;
        for (int i = 0; i < 4; i++) send(64'(200 + i));
        rdy_mode = 1;
        bus.o_tready = 1'b1;
        first_acc = 0;
        for (int i = 0; i < 20; i++) begin
            send(64'(300 + i));
            if (i == 0) first_acc = last_acc;
        end
        check("throughput_cycles", 65'(last_acc - first_acc), 65'd19);
        drain();

        // Clear discards a pending escape.
        rdy_mode = 0;
        bus.o_tready = 1'b0;
        send(ESC);
        do_clear();
        check("clear_occupied", 65'(occupied), 65'd0);
        send(64'd4);
        check("clear_then_occupied", 65'(occupied), 65'd1);
        check("clear_then_o_tdata", 65'(bus.o_tdata), 65'd4);
        check("clear_then_o_tlast", 65'(bus.o_tlast), 65'd0);
        drain();

        // Random traffic with escapes, control words, bubbles and downstream stalls.
        rdy_mode = 2;
        prev = 64'd0;
        for (int i = 0; i < 400; i++) begin
            if (i == 200) do_clear();
            if (prev == ESC) begin
                case ($urandom_range(0, 3))
                    0: w = 64'd0;
                    1: w = 64'd1;
                    2: w = 64'($urandom_range(2, 9));
                    default: w = {$urandom, $urandom};
                endcase
            end else if ($urandom_range(0, 9) < 2) begin
                w = ESC;
            end else begin
                w = {$urandom, $urandom};
            end
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk);
                #1;
            end
            send(w);
            prev = (mstate == 1) ? ESC : 64'd0;
        end
        drain();
`ifdef AXI_EXTRACT_TLAST_STATS_EN
        check("pkt_count", 65'(pkt_count), 65'(pkt_model));
        check("esc_count", 65'(esc_count), 65'(esc_model));
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
